ser_frame_tx: RTL and testbench

Parallel-to-serial framer that sits directly upstream of the overlapping Mealy sequence detectors and drives their `ser_in` input. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock, MSB- or LSB-first. It supports back-to-back words with no idle gap and holds a fixed idle level between frames. The detector is free-running, so the idle level keeps it parked in its reset state between words.

---
 rtl/ser_frame_tx.sv | 99 +++++++++
 tb/tb_ser_frame_tx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ser_frame_tx.sv
// Parallel-to-serial framer: shifts WIDTH-bit words out one bit per clock, MSB- or LSB-first.
// Latency: a word accepted at edge k drives ser_out in cycles k+1..k+WIDTH; frame_done marks the last bit.
// Backpressure: din_ready is high in IDLE or on the last bit of a frame, so words chain with no gap.
module ser_frame_tx #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             ser_out,
   output logic             ser_active,
   output logic             frame_done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ser_out_q, ser_out_d;
   logic             ser_active_q, ser_active_d;
   logic             frame_done_q, frame_done_d;
   logic             accept;

   // Ready while idle, or while the last bit of the current word is on the wire.
   assign din_ready = (state_q == S_IDLE) || ((state_q == S_SHIFT) && (cnt_q == '0));
   assign accept    = din_valid && din_ready;

   assign ser_out    = ser_out_q;
   assign ser_active = ser_active_q;
   assign frame_done = frame_done_q;

   // Next-state logic: load a new word, shift the current one, or fall back to the idle level.
   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      cnt_d        = cnt_q;
      ser_out_d    = IDLE_BIT;
      ser_active_d = 1'b0;
      frame_done_d = 1'b0;

      if ((state_q == S_SHIFT) && (cnt_q != '0)) begin
         // Mid-frame: the next bit sits at the outgoing end of sr.
         if (MSB_FIRST != 0) begin
            ser_out_d = sr_q[WIDTH-1];
            sr_d      = sr_q << 1;
         end else begin
            ser_out_d = sr_q[0];
            sr_d      = sr_q >> 1;
         end
         cnt_d        = cnt_q - CW'(1);
         ser_active_d = 1'b1;
         frame_done_d = (cnt_q == CW'(1));
      end else if (accept) begin
         // From IDLE or on the last bit: first bit goes straight to ser_out, the rest into sr.
         if (MSB_FIRST != 0) begin
            ser_out_d = din[WIDTH-1];
            sr_d      = din << 1;
         end else begin
            ser_out_d = din[0];
            sr_d      = din >> 1;
         end
         cnt_d        = CW'(WIDTH - 1);
         ser_active_d = 1'b1;
         state_d      = S_SHIFT;
      end else begin
         state_d = S_IDLE;
      end
   end

   // State and output registers; reset parks the line at the idle level immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         sr_q         <= '0;
         cnt_q        <= '0;
         ser_out_q    <= IDLE_BIT;
         ser_active_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         cnt_q        <= cnt_d;
         ser_out_q    <= ser_out_d;
         ser_active_q <= ser_active_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_ser_frame_tx.sv
// Bench for ser_frame_tx: one MSB-first and one LSB-first instance on a shared clock and reset.
// Per-cycle vector table plus hand-written sequences for async reset and a 1001 detector chain.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_ser_frame_tx;

   logic       clk;
   logic       rst_n;
   logic [7:0] m_din, l_din;
   logic       m_vld, l_vld;
   logic       m_rdy, l_rdy;
   logic       m_ser, l_ser;
   logic       m_act, l_act;
   logic       m_done, l_done;

   int checks;
   int failures;

   ser_frame_tx #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_msb (
      .clk        (clk),
      .rst        (rst_n),
      .din        (m_din),
      .din_valid  (m_vld),
      .din_ready  (m_rdy),
      .ser_out    (m_ser),
      .ser_active (m_act),
      .frame_done (m_done)
   );

   ser_frame_tx #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u_lsb (
      .clk        (clk),
      .rst        (rst_n),
      .din        (l_din),
      .din_valid  (l_vld),
      .din_ready  (l_rdy),
      .ser_out    (l_ser),
      .ser_active (l_act),
      .frame_done (l_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit       lsb;
      bit       rst_n;
      bit       vld;
      bit [7:0] din;
      bit       e_ser;
      bit       e_act;
      bit       e_done;
      bit       e_rdy;
      string    tag;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input bit lsb, input bit rn, input bit vld, input bit [7:0] din,
                               input bit es, input bit ea, input bit ed, input bit er,
                               input string tag);
      vec_t v;
      v.lsb = lsb; v.rst_n = rn; v.vld = vld; v.din = din;
      v.e_ser = es; v.e_act = ea; v.e_done = ed; v.e_rdy = er; v.tag = tag;
      vecs.push_back(v);
   endfunction

   task automatic check_msb(input string tag, input bit es, input bit ea, input bit ed, input bit er);
      check({tag, ".ser_out"},    {31'd0, m_ser},  {31'd0, es});
      check({tag, ".ser_active"}, {31'd0, m_act},  {31'd0, ea});
      check({tag, ".frame_done"}, {31'd0, m_done}, {31'd0, ed});
      check({tag, ".din_ready"},  {31'd0, m_rdy},  {31'd0, er});
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0]  pat;
      logic [15:0] stream;
      logic [3:0]  hist;
      int          hits;
      int          act_cycles;

      checks   = 0;
      failures = 0;
      rst_n = 1'b0;
      m_vld = 1'b0; m_din = 8'h00;
      l_vld = 1'b0; l_din = 8'h00;

      // Reset held 3 cycles with valid asserted: idle outputs, ready high, nothing captured.
      for (int i = 0; i < 3; i++) add(0, 0, 1, 8'hA5, 0, 0, 0, 1, "reset");
      add(1, 0, 1, 8'h5A, 0, 0, 0, 1, "reset_lsb");

      // Single word A5, MSB-first; din is scrambled after the accept edge.
      add(0, 1, 1, 8'hA5, 0, 0, 0, 1, "single_acc");
      pat = 8'hA5;
      for (int i = 0; i < 8; i++)
         add(0, 1, 0, 8'h3C, pat[7-i], 1, (i == 7), (i == 7), $sformatf("single_b%0d", i));
      add(0, 1, 0, 8'h00, 0, 0, 0, 1, "single_idle");

      // Back-to-back 90 then 9F with valid held until the second accept.
      add(0, 1, 1, 8'h90, 0, 0, 0, 1, "b2b_acc");
      stream = 16'b1001000010011111;
      for (int i = 0; i < 16; i++)
         add(0, 1, (i < 8), 8'h9F, stream[15-i], 1, (i == 7 || i == 15), (i == 7 || i == 15),
             $sformatf("b2b_b%0d", i));
      add(0, 1, 0, 8'h00, 0, 0, 0, 1, "b2b_idle");

      // LSB-first 01; second word 80 offered from cycle k+3, taken only at k+8.
      add(1, 1, 1, 8'h01, 0, 0, 0, 1, "lsb_acc");
      stream = 16'b1000000000000001;
      for (int i = 0; i < 16; i++)
         add(1, 1, (i >= 2 && i <= 7), 8'h80, stream[15-i], 1, (i == 7 || i == 15),
             (i == 7 || i == 15), $sformatf("lsb_b%0d", i));
      add(1, 1, 0, 8'h00, 0, 0, 0, 1, "lsb_idle");

      foreach (vecs[n]) begin
         rst_n = vecs[n].rst_n;
         m_vld = vecs[n].lsb ? 1'b0 : vecs[n].vld;
         m_din = vecs[n].lsb ? 8'h00 : vecs[n].din;
         l_vld = vecs[n].lsb ? vecs[n].vld : 1'b0;
         l_din = vecs[n].lsb ? vecs[n].din : 8'h00;
         @(negedge clk);
         if (vecs[n].lsb) begin
            check({vecs[n].tag, ".ser_out"},    {31'd0, l_ser},  {31'd0, vecs[n].e_ser});
            check({vecs[n].tag, ".ser_active"}, {31'd0, l_act},  {31'd0, vecs[n].e_act});
            check({vecs[n].tag, ".frame_done"}, {31'd0, l_done}, {31'd0, vecs[n].e_done});
            check({vecs[n].tag, ".din_ready"},  {31'd0, l_rdy},  {31'd0, vecs[n].e_rdy});
         end else begin
            check_msb(vecs[n].tag, vecs[n].e_ser, vecs[n].e_act, vecs[n].e_done, vecs[n].e_rdy);
         end
         next_cycle();
      end
      l_vld = 1'b0;

      // Async reset during bit 4 of FF: outputs drop before any clock edge.
      m_vld = 1'b1; m_din = 8'hFF;
      @(negedge clk);
      check_msb("ar_acc", 0, 0, 0, 1);
      next_cycle();
      m_vld = 1'b0; m_din = 8'h00;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_msb($sformatf("ar_b%0d", i), 1, 1, 0, 0);
         if (i < 3) next_cycle();
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_msb("ar_async", 0, 0, 0, 1);
      next_cycle();
      rst_n = 1'b1; m_vld = 1'b1; m_din = 8'h0F;
      @(negedge clk);
      check_msb("ar_rel", 0, 0, 0, 1);
      next_cycle();
      m_vld = 1'b0; m_din = 8'h00;
      pat = 8'h0F;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_msb($sformatf("ar_0f_b%0d", i), pat[7-i], 1, (i == 7), (i == 7));
         next_cycle();
      end
      @(negedge clk);
      check_msb("ar_idle", 0, 0, 0, 1);
      next_cycle();

      // Chained 1001 overlapping detector on 99 then 90.
      hist = 4'b0000; hits = 0; act_cycles = 0;
      m_vld = 1'b1; m_din = 8'h99;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         hist = {hist[2:0], m_ser};
         if (hist == 4'b1001) hits++;
         if (m_act) act_cycles++;
         next_cycle();
         if (c == 0) m_din = 8'h90;
         if (c == 8) m_vld = 1'b0;
      end
      check("det_hits", hits, 3);
      check("det_active_cycles", act_cycles, 16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
